// File: rtl/kiwi_rx_frame_sched.sv
// kiwi_rx_frame_sched
// Interleaves the per-channel decimated I/Q samples of the receiver bank onto
// one AXI4-Stream. Each frame carries exactly one beat per enabled channel, in
// ascending channel order. Every beat is tagged with its channel index, and
// tlast marks the highest enabled channel. The enable mask is latched only at
// frame boundaries, so software always sees a fixed frame layout.
//
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   cfg_mask        channel enable mask (bit n = channel n)
//   s_axis_*        per-channel sample inputs; channel n data at
//                   [n*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_*        scheduled output stream; tuser = channel index
//   sts_frames      completed-frame counter (wraps)
//   sts_busy        high while a frame is in progress
module kiwi_rx_frame_sched #(
  parameter int CHANNELS   = 8,
  parameter int DATA_WIDTH = 64,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [CHANNELS-1:0]            cfg_mask,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  output logic [CHANNELS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [CW-1:0]                  m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [31:0]                    sts_frames,
  output logic                           sts_busy
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FRAME = 1'b1;

  logic                  state_q, state_d;
  logic [CHANNELS-1:0]   active_mask_q, active_mask_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [31:0]           frames_q, frames_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [CW-1:0]         tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;

  logic [DATA_WIDTH-1:0] slice [CHANNELS];
  logic [CHANNELS-1:0]   ready;
  logic                  out_free;
  logic                  xfer;
  logic                  is_last;

  function automatic logic [CW-1:0] lowest_bit(input logic [CHANNELS-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i]) r = CW'(i);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] highest_bit(input logic [CHANNELS-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (m[i]) r = CW'(i);
    end
    return r;
  endfunction

  // Next enabled channel strictly above p; only called when one exists.
  function automatic logic [CW-1:0] next_bit(input logic [CHANNELS-1:0] m,
                                             input logic [CW-1:0] p);
    logic [CW-1:0] r;
    r = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(p))) r = CW'(i);
    end
    return r;
  endfunction

  // The output register can accept a new beat when empty or draining now.
  assign out_free = !tvalid_q || m_axis_tready;

  // Only the pointed channel is ever offered ready.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign slice[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ready[gi] = (state_q == ST_FRAME) && out_free && (ptr_q == CW'(gi));
  end

  assign xfer    = |(ready & s_axis_tvalid);
  assign is_last = (ptr_q == highest_bit(active_mask_q));

  always_comb begin
    state_d       = state_q;
    active_mask_d = active_mask_q;
    ptr_d         = ptr_q;
    frames_d      = frames_q;
    tvalid_d      = tvalid_q;
    tdata_d       = tdata_q;
    tuser_d       = tuser_q;
    tlast_d       = tlast_q;

    // Drain a consumed beat; a same-cycle transfer below reloads it.
    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|cfg_mask) begin
          active_mask_d = cfg_mask;
          ptr_d         = lowest_bit(cfg_mask);
          state_d       = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (xfer) begin
          tdata_d  = slice[ptr_q];
          tuser_d  = ptr_q;
          tvalid_d = 1'b1;
          tlast_d  = is_last;
          if (!is_last) begin
            ptr_d = next_bit(active_mask_q, ptr_q);
          end else begin
            frames_d = frames_q + 32'd1;
            // Back-to-back frames: relatch the mask with no bubble cycle.
            if (|cfg_mask) begin
              active_mask_d = cfg_mask;
              ptr_d         = lowest_bit(cfg_mask);
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      active_mask_q <= '0;
      ptr_q         <= '0;
      frames_q      <= '0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      tuser_q       <= '0;
      tlast_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_mask_q <= active_mask_d;
      ptr_q         <= ptr_d;
      frames_q      <= frames_d;
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
    end
  end

  assign s_axis_tready = ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign sts_frames    = frames_q;
  assign sts_busy      = (state_q == ST_FRAME);

endmodule
